// File: rtl/mod_shiftmix_if.sv
// Byte-state handshake between the SubBytes stage and the ShiftRows/MixColumns stage.
// p and o are addressed as [row][column][bit].
interface mod_shiftmix_if;
    logic                  load;
    logic                  bypass;
    logic [3:0][3:0][7:0]  p;
    logic [3:0][3:0][7:0]  o;
    logic                  valid;
    logic                  busy;

    modport master (
        output load, bypass, p,
        input  o, valid, busy
    );

    modport slave (
        input  load, bypass, p,
        output o, valid, busy
    );
endinterface

// File: rtl/mod_shiftmix.sv
// AES ShiftRows + iterative MixColumns stage.
// ShiftRows is applied while capturing the state. MixColumns then runs one column
// per clock. A bypass transfer (final round) skips MixColumns and completes in one cycle.
module mod_shiftmix (
    input  logic           clk,
    input  logic           rst,
    mod_shiftmix_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef logic [3:0][3:0][7:0] arr_t;

    state_e      state_q, state_d;
    logic [1:0]  col_q, col_d;
    arr_t        w_q, w_d;
    arr_t        o_q, o_d;
    arr_t        shifted;
    arr_t        mixed;

    // GF(2^8) multiply by x modulo the AES polynomial
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotated left by r byte positions
    function automatic arr_t shift_rows(input arr_t s);
        arr_t t;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[2'(r)][2'(c)] = s[2'(r)][2'(c + r)];
            end
        end
        return t;
    endfunction

    // Replace column c of s with its MixColumns transform, other columns untouched
    function automatic arr_t mix_one(input arr_t s, input logic [1:0] c);
        arr_t       t;
        logic [7:0] a0, a1, a2, a3;
        t  = s;
        a0 = s[0][c];
        a1 = s[1][c];
        a2 = s[2][c];
        a3 = s[3][c];
        t[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return t;
    endfunction

    assign shifted = shift_rows(bus.p);
    assign mixed   = mix_one(w_q, col_q);

    // Next-state: capture with ShiftRows in IDLE/DONE, one column per cycle in CALC
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        w_d     = w_q;
        o_d     = o_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.load) begin
                    w_d = shifted;
                    if (bus.bypass) begin
                        // Final round: result is the shifted state itself
                        o_d     = shifted;
                        state_d = DONE;
                    end else begin
                        col_d   = 2'd0;
                        state_d = CALC;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                w_d   = mixed;
                col_d = 2'(col_q + 2'd1);
                if (col_q == 2'd3) begin
                    // Only the complete array ever reaches the outputs
                    o_d     = mixed;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working array and output registers; reset abandons any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            w_q     <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            w_q     <= w_d;
            o_q     <= o_d;
        end
    end

    assign bus.o     = o_q;
    assign bus.valid = (state_q == DONE);
    assign bus.busy  = (state_q == CALC);

endmodule

// File: tb/tb_mod_shiftmix.sv
// Bench for mod_shiftmix: directed AES vectors plus random transfers
// compared against a plain GF(2^8) reference model.
module tb_mod_shiftmix;

    typedef logic [3:0][3:0][7:0] state_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    state_t last_exp;

    mod_shiftmix_if bus ();

    mod_shiftmix dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // General GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        logic [7:0] bb;
        acc = 8'h00;
        aa  = a;
        bb  = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) acc = acc ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return acc;
    endfunction

    // Reference: ShiftRows, then (unless final round) the circulant {02,03,01,01} matrix
    function automatic state_t model(input state_t p, input logic byp);
        state_t s;
        state_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = p[r][(c + r) % 4];
        if (byp) return s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = gmul(8'h02, s[r][c]) ^ gmul(8'h03, s[(r + 1) % 4][c])
                        ^ s[(r + 2) % 4][c] ^ s[(r + 3) % 4][c];
        return m;
    endfunction

    // Build a state from four rows written left (column 0) to right
    function automatic state_t mk(input logic [31:0] r0, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [31:0] r3);
        state_t s;
        logic [31:0] rows [4];
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = rows[r][31 - 8 * c -: 8];
        return s;
    endfunction

    function automatic state_t rnd_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a state, then scramble the inputs so late sampling would be noticed
    task automatic start(input state_t d, input logic byp);
        bus.p      = d;
        bus.bypass = byp;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.p      = rnd_state();
        bus.bypass = 1'($urandom_range(0, 1));
    endtask

    // One full transfer with exact-latency checks
    task automatic run_xfer(input state_t d, input logic byp, input string name);
        state_t exp;
        exp = model(d, byp);
        start(d, byp);
        if (!byp) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.o !== last_exp) begin
                    errors++;
                    $display("FAIL %s calc%0d: busy=%b valid=%b o=%h, want busy=1 valid=0 o=%h",
                             name, i, bus.busy, bus.valid, bus.o, last_exp);
                end
                if (i < 3) tick();
            end
            tick();
        end
        checks++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b0 || bus.o !== exp) begin
            errors++;
            $display("FAIL %s result: valid=%b busy=%b o=%h, want valid=1 busy=0 o=%h",
                     name, bus.valid, bus.busy, bus.o, exp);
        end
        last_exp = exp;
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.o !== exp) begin
            errors++;
            $display("FAIL %s after: valid=%b o=%h, want valid=0 o=%h",
                     name, bus.valid, bus.o, exp);
        end
    endtask

    task automatic test_reset();
        state_t d;
        rst        = 1'b1;
        bus.load   = 1'b0;
        bus.bypass = 1'b0;
        bus.p      = '0;
        last_exp   = '0;
        repeat (2) tick();
        checks++;
        if (bus.o !== '0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: o=%h valid=%b busy=%b, want all 0",
                     bus.o, bus.valid, bus.busy);
        end
        rst = 1'b0;
        tick();
        run_xfer(rnd_state(), 1'b1, "reset_pre");
        // Abort a MixColumns transfer partway through
        start(rnd_state(), 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.o !== '0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: o=%h valid=%b busy=%b, want all 0",
                     bus.o, bus.valid, bus.busy);
        end
        tick();
        rst      = 1'b0;
        last_exp = '0;
        repeat (5) begin
            tick();
            checks++;
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_abandon: valid=%b busy=%b, want 0 0", bus.valid, bus.busy);
            end
        end
        d = rnd_state();
        run_xfer(d, 1'b1, "reset_clean");
    endtask

    task automatic test_shiftrows();
        state_t d;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                d[r][c] = {4'(r), 4'(c)};
        start(d, 1'b1);
        checks++;
        if (bus.valid !== 1'b1 || bus.o[0][1] !== 8'h01 || bus.o[1][0] !== 8'h11 ||
            bus.o[1][3] !== 8'h10 || bus.o[2][2] !== 8'h20 || bus.o[2][3] !== 8'h21 ||
            bus.o[3][0] !== 8'h33 || bus.o[3][1] !== 8'h30 || bus.o[3][3] !== 8'h32) begin
            errors++;
            $display("FAIL shiftrows: valid=%b o=%h", bus.valid, bus.o);
        end
        checks++;
        if (bus.o !== model(d, 1'b1)) begin
            errors++;
            $display("FAIL shiftrows_full: o=%h, want %h", bus.o, model(d, 1'b1));
        end
        last_exp = model(d, 1'b1);
        tick();
    endtask

    task automatic test_fips();
        state_t d;
        state_t want;
        d    = mk(32'hd4e0b81e, 32'h27bfb441, 32'h11985d52, 32'haef1e530);
        want = mk(32'h04e04828, 32'h66cbf806, 32'h8119d326, 32'he59a7a4c);
        run_xfer(d, 1'b0, "fips");
        checks++;
        if (bus.o !== want) begin
            errors++;
            $display("FAIL fips_const: o=%h, want %h", bus.o, want);
        end
    endtask

    task automatic test_columns();
        state_t d;
        d = '0;
        d[0][0] = 8'hdb; d[1][1] = 8'h13; d[2][2] = 8'h53; d[3][3] = 8'h45;
        run_xfer(d, 1'b0, "col_db");
        checks++;
        if (bus.o[0][0] !== 8'h8e || bus.o[1][0] !== 8'h4d ||
            bus.o[2][0] !== 8'ha1 || bus.o[3][0] !== 8'hbc) begin
            errors++;
            $display("FAIL col_db_const: col0=%h %h %h %h, want 8e 4d a1 bc",
                     bus.o[0][0], bus.o[1][0], bus.o[2][0], bus.o[3][0]);
        end
        d = {16{8'h01}};
        run_xfer(d, 1'b0, "col_01");
        checks++;
        if (bus.o !== d) begin
            errors++;
            $display("FAIL col_01_ident: o=%h, want %h", bus.o, d);
        end
        d = {16{8'hc6}};
        run_xfer(d, 1'b0, "col_c6");
        checks++;
        if (bus.o !== d) begin
            errors++;
            $display("FAIL col_c6_ident: o=%h, want %h", bus.o, d);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_xfer(rnd_state(), 1'($urandom_range(0, 1)), "random");
    endtask

    task automatic test_handshake();
        state_t a;
        state_t b;
        state_t ea;
        state_t eb;
        a  = rnd_state();
        b  = rnd_state();
        ea = model(a, 1'b0);
        eb = model(b, 1'b0);
        bus.p      = a;
        bus.bypass = 1'b0;
        bus.load   = 1'b1;
        tick();
        // Keep requesting with different data while busy; must be ignored
        bus.p      = rnd_state();
        bus.bypass = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.o !== last_exp) begin
                errors++;
                $display("FAIL hs_ignore%0d: busy=%b valid=%b o=%h, want busy=1 valid=0 o=%h",
                         i, bus.busy, bus.valid, bus.o, last_exp);
            end
            if (i < 3) tick();
        end
        tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b0 || bus.o !== ea) begin
            errors++;
            $display("FAIL hs_first: valid=%b busy=%b o=%h, want valid=1 busy=0 o=%h",
                     bus.valid, bus.busy, bus.o, ea);
        end
        // load still high in DONE with the next state: accepted
        bus.p      = b;
        bus.bypass = 1'b0;
        tick();
        bus.load   = 1'b0;
        bus.p      = rnd_state();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.o !== ea) begin
                errors++;
                $display("FAIL hs_second_calc%0d: busy=%b valid=%b o=%h, want busy=1 valid=0 o=%h",
                         i, bus.busy, bus.valid, bus.o, ea);
            end
            if (i < 3) tick();
        end
        tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.o !== eb) begin
            errors++;
            $display("FAIL hs_second: valid=%b o=%h, want valid=1 o=%h", bus.valid, bus.o, eb);
        end
        last_exp = eb;
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hs_idle: valid=%b busy=%b, want 0 0", bus.valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        state_t d;
        for (int i = 0; i < 3; i++) begin
            d          = rnd_state();
            bus.p      = d;
            bus.bypass = 1'b1;
            bus.load   = 1'b1;
            tick();
            checks++;
            if (bus.valid !== 1'b1 || bus.busy !== 1'b0 || bus.o !== model(d, 1'b1)) begin
                errors++;
                $display("FAIL b2b%0d: valid=%b busy=%b o=%h, want valid=1 busy=0 o=%h",
                         i, bus.valid, bus.busy, bus.o, model(d, 1'b1));
            end
            last_exp = model(d, 1'b1);
        end
        bus.load = 1'b0;
        bus.p    = rnd_state();
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.o !== last_exp) begin
            errors++;
            $display("FAIL b2b_end: valid=%b o=%h, want valid=0 o=%h", bus.valid, bus.o, last_exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_shiftrows();
        test_fips();
        test_columns();
        test_random();
        test_handshake();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
